obi_mem_responder: RTL

Word-addressed memory responder for the RISC-V core's OBI-style instruction or data port (req/gnt/rvalid, no rready). It answers one transaction per cycle with a fixed, parameterised response latency. A host load/readback port lets the stream side preload programs and read results. Two instances, instruction and data, sit beside the core in the fullchip test wrapper.

---
 rtl/obi_mem_responder_if.sv | 27 ++
 rtl/obi_mem_responder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/obi_mem_responder_if.sv
// obi_mem_responder_if
//   Bundles the OBI-style core port (req/gnt/rvalid, no rready) of the memory
//   responder.
//   master : core side, drives the request attributes and receives gnt/response.
//   slave  : memory side, drives gnt and the response.
`timescale 1ns/1ps

interface obi_mem_responder_if;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/obi_mem_responder.sv
// obi_mem_responder
//   Word-addressed memory for an OBI-style core port. Grants one transaction
//   per cycle and answers after a fixed RESP_LATENCY. A host port preloads
//   programs and reads results back.
// Ports:
//   clk, resetb             : single clock, asynchronous active-low reset
//   bus (slave)             : core req/gnt/we/be/addr/wdata, rvalid/rdata
//   stall_i                 : tester stall, forces gnt low
//   host_en/host_we         : host access this cycle, write (1) / read (0)
//   host_addr/host_wdata    : host word index and write data
//   host_rvalid/host_rdata  : registered host read result, one cycle later
//   rd_count/wr_count       : saturating counts of granted core reads/writes
`timescale 1ns/1ps

module obi_mem_responder #(
    parameter int          DEPTH_LOG2   = 11,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          RESP_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetb,
    obi_mem_responder_if.slave    bus,
    input  logic                  stall_i,
    input  logic                  host_en,
    input  logic                  host_we,
    input  logic [DEPTH_LOG2-1:0] host_addr,
    input  logic [31:0]           host_wdata,
    output logic                  host_rvalid,
    output logic [31:0]           host_rdata,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic                  gnt;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           resp_data;
    logic                  unused_addr_bits;

    logic [RESP_LATENCY-1:0] pipe_valid;
    logic [31:0]             pipe_data [RESP_LATENCY];

    // Host access has absolute priority over the core.
    assign gnt        = bus.req_i & ~stall_i & ~host_en;
    assign bus.gnt_o  = gnt;

    assign word_idx   = bus.addr_i[DEPTH_LOG2+1:2];
    assign in_range   = (bus.addr_i[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    // Byte offset within the word plays no part in addressing.
    assign unused_addr_bits = ^bus.addr_i[1:0];

    // Writes and out-of-range reads answer with zero data.
    assign resp_data  = (in_range && !bus.we_i) ? mem[word_idx] : 32'h0;

    // NOTE: the memory array has no reset so that preloaded contents survive
    // resetb; only control state below is reset.
    always_ff @(posedge clk) begin
        if (host_en && host_we) begin
            mem[host_addr] <= host_wdata;
        end else if (gnt && bus.we_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Response shift register. A data stage only loads when a valid entry
    // moves in, so the last stage holds its value through idle cycles.
    // NOTE: all sequential state uses non-blocking assignments so every stage
    // samples the value from before the clock edge.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pipe_valid <= '0;
            for (int i = 0; i < RESP_LATENCY; i++) begin
                pipe_data[i] <= 32'h0;
            end
        end else begin
            pipe_valid[0] <= gnt;
            if (gnt) begin
                pipe_data[0] <= resp_data;
            end
            for (int i = 1; i < RESP_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign bus.rvalid_o = pipe_valid[RESP_LATENCY-1];
    assign bus.rdata_o  = pipe_data[RESP_LATENCY-1];

    // Host readback and saturating transaction counters.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            host_rvalid <= 1'b0;
            host_rdata  <= 32'h0;
            rd_count    <= 16'h0;
            wr_count    <= 16'h0;
        end else begin
            host_rvalid <= host_en & ~host_we;
            if (host_en && !host_we) begin
                host_rdata <= mem[host_addr];
            end
            if (gnt && !bus.we_i && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
            if (gnt && bus.we_i && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule
